// File: rtl/surf_cmd_pkg.sv
// surf_cmd_pkg
//   Frame layout shared by the TURF event-generator transmitter and the SURF
//   command receiver.
//   Frame, MSB first: start(1) | buffer | evid | even parity | stop(0)
//   Contents:
//     cmd_state_t  - receiver state encoding
//     frame_len()  - total bits per frame for a given field layout
//     even_parity()- parity bit that makes buffer+evid+parity even
package surf_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } cmd_state_t;

  function automatic int frame_len(input int buf_bits, input int evid_bits);
    return buf_bits + evid_bits + 3;
  endfunction

  // Zero-extended payload in; the returned bit is the transmitted parity bit.
  function automatic logic even_parity(input logic [31:0] payload);
    return ^payload;
  endfunction

endpackage

// File: rtl/cmd_line_sync.sv
// cmd_line_sync
//   Brings the asynchronous CMD line into the clock domain and finds rising
//   edges of the synchronised value.
//   Ports:
//     clk        - receiver clock
//     rst        - asynchronous active-high reset
//     cmd_async  - raw CMD line (idle low)
//     cmd_sync   - line after the 2-flop synchroniser (2 cycles latency)
//     cmd_rise   - cmd_sync high while the history flop is still low
module cmd_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic cmd_async,
  output logic cmd_sync,
  output logic cmd_rise
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      meta_q <= cmd_async;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign cmd_sync = sync_q;
  assign cmd_rise = sync_q & ~hist_q;

endmodule

// File: rtl/surf_cmd_receiver.sv
// surf_cmd_receiver
//   Decodes the per-SURF serial CMD line: frames each digitize command,
//   checks parity and stop bit, and hands buffer/evid to the readout logic.
//   Optional build macro: SURF_CMD_ERR_COUNT_EN adds a saturating 16-bit
//   error counter (err_count_o) with a synchronous clear (err_count_clr_i).
//   Ports:
//     clk125_i, rst_i   - clock, asynchronous active-high reset
//     CMD_i             - raw serial command line, idle low
//     cmd_valid_o       - decoded command pending
//     cmd_ack_i         - consumer accepts pending command
//     cmd_buffer_o      - decoded buffer number
//     cmd_evid_o        - decoded event-ID bits
//     err_parity_o      - 1-cycle pulse, frame dropped for bad parity
//     err_frame_o       - 1-cycle pulse, bad stop bit or start glitch
//     err_overrun_o     - sticky, good frame arrived while one was unacked
//     busy_o            - frame reception in progress
//
// Handshake: cmd_valid_o rises one cycle after a good stop-bit sample and
// cmd_buffer_o/cmd_evid_o are stable while it is high. A command retires on
// the clock edge where cmd_ack_i and cmd_valid_o are both high; an ack with
// nothing pending is ignored. A new frame landing on that same edge replaces
// the retiring one (valid stays high); landing while unacked it is dropped.
module surf_cmd_receiver
  import surf_cmd_pkg::*;
#(
  parameter int BIT_CLKS  = 4,
  parameter int EVID_BITS = 12,
  parameter int BUF_BITS  = 2
) (
  input  logic                 clk125_i,
  input  logic                 rst_i,
  input  logic                 CMD_i,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ack_i,
  output logic [BUF_BITS-1:0]  cmd_buffer_o,
  output logic [EVID_BITS-1:0] cmd_evid_o,
  output logic                 err_parity_o,
  output logic                 err_frame_o,
  output logic                 err_overrun_o,
`ifdef SURF_CMD_ERR_COUNT_EN
  input  logic                 err_count_clr_i,
  output logic [15:0]          err_count_o,
`endif
  output logic                 busy_o
);

  localparam int DW = BUF_BITS + EVID_BITS;
  localparam int PW = $clog2(BIT_CLKS);
  localparam int CW = $clog2(frame_len(BUF_BITS, EVID_BITS));

  // Start is sampled half a bit in; once aligned there, every later sample
  // lands one full bit later, i.e. mid-bit.
  localparam logic [PW-1:0] PH_HALF  = PW'(BIT_CLKS / 2 - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(DW - 1);

  logic          line;
  logic          line_rise;
  cmd_state_t    state_q;
  logic [PW-1:0] phase_q;
  logic [CW-1:0] bit_cnt_q;
  logic [DW-1:0] shift_q;
  logic          par_bit_q;
  logic          armed_q;   // line seen low since the last return to IDLE
  logic          parity_ok;

  cmd_line_sync u_sync (
    .clk       (clk125_i),
    .rst       (rst_i),
    .cmd_async (CMD_i),
    .cmd_sync  (line),
    .cmd_rise  (line_rise)
  );

  assign parity_ok = (even_parity(32'(shift_q)) == par_bit_q);
  assign busy_o    = (state_q != ST_IDLE);

  always_ff @(posedge clk125_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_bit_q     <= 1'b0;
      armed_q       <= 1'b0;
      cmd_valid_o   <= 1'b0;
      cmd_buffer_o  <= '0;
      cmd_evid_o    <= '0;
      err_parity_o  <= 1'b0;
      err_frame_o   <= 1'b0;
      err_overrun_o <= 1'b0;
    end else begin
      err_parity_o <= 1'b0;
      err_frame_o  <= 1'b0;
      if (cmd_ack_i && cmd_valid_o) cmd_valid_o <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (line_rise && armed_q) begin
            state_q <= ST_START;
            phase_q <= '0;
            armed_q <= 1'b0;
          end else if (!line) begin
            armed_q <= 1'b1;
          end
        end

        ST_START: begin
          if (phase_q == PH_HALF) begin
            phase_q <= '0;
            if (line) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end else begin
              err_frame_o <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (phase_q == PH_LAST) begin
            phase_q   <= '0;
            shift_q   <= {shift_q[DW-2:0], line};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) state_q <= ST_PARITY;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end

        ST_PARITY: begin
          if (phase_q == PH_LAST) begin
            phase_q   <= '0;
            par_bit_q <= line;
            state_q   <= ST_STOP;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end

        ST_STOP: begin
          if (phase_q == PH_LAST) begin
            phase_q   <= '0;
            bit_cnt_q <= '0;
            state_q   <= ST_IDLE;
            if (line) begin
              // A bad stop bit makes the parity bit meaningless; only the
              // framing error is reported.
              err_frame_o <= 1'b1;
            end else if (!parity_ok) begin
              err_parity_o <= 1'b1;
            end else if (!cmd_valid_o || cmd_ack_i) begin
              cmd_valid_o  <= 1'b1;
              cmd_buffer_o <= shift_q[DW-1 -: BUF_BITS];
              cmd_evid_o   <= shift_q[EVID_BITS-1:0];
            end else begin
              err_overrun_o <= 1'b1;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          phase_q <= '0;
        end
      endcase
    end
  end

`ifdef SURF_CMD_ERR_COUNT_EN
  // Clear wins over a coincident error pulse.
  always_ff @(posedge clk125_i or posedge rst_i) begin
    if (rst_i) begin
      err_count_o <= '0;
    end else if (err_count_clr_i) begin
      err_count_o <= '0;
    end else if ((err_parity_o || err_frame_o) && (err_count_o != 16'hFFFF)) begin
      err_count_o <= err_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_surf_cmd_receiver.sv
// tb_surf_cmd_receiver
//   Directed bench for surf_cmd_receiver with BIT_CLKS=4, BUF_BITS=2,
//   EVID_BITS=12 (17-bit frames). Inputs change and outputs are sampled on
//   the falling clock edge. Define SURF_CMD_ERR_COUNT_EN to also exercise
//   the error counter.
module tb_surf_cmd_receiver;

  localparam int BIT_CLKS  = 4;
  localparam int EVID_BITS = 12;
  localparam int BUF_BITS  = 2;
  localparam int FL        = BUF_BITS + EVID_BITS + 3;

  logic                 clk;
  logic                 rst;
  logic                 cmd_line;
  logic                 cmd_valid;
  logic                 cmd_ack;
  logic [BUF_BITS-1:0]  cmd_buffer;
  logic [EVID_BITS-1:0] cmd_evid;
  logic                 err_parity;
  logic                 err_frame;
  logic                 err_overrun;
  logic                 busy;
`ifdef SURF_CMD_ERR_COUNT_EN
  logic                 err_count_clr;
  logic [15:0]          err_count;
`endif

  int n_cmp;
  int n_err;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  surf_cmd_receiver #(
    .BIT_CLKS  (BIT_CLKS),
    .EVID_BITS (EVID_BITS),
    .BUF_BITS  (BUF_BITS)
  ) dut (
    .clk125_i        (clk),
    .rst_i           (rst),
    .CMD_i           (cmd_line),
    .cmd_valid_o     (cmd_valid),
    .cmd_ack_i       (cmd_ack),
    .cmd_buffer_o    (cmd_buffer),
    .cmd_evid_o      (cmd_evid),
    .err_parity_o    (err_parity),
    .err_frame_o     (err_frame),
    .err_overrun_o   (err_overrun),
`ifdef SURF_CMD_ERR_COUNT_EN
    .err_count_clr_i (err_count_clr),
    .err_count_o     (err_count),
`endif
    .busy_o          (busy)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [FL-1:0] mk_frame(input logic [BUF_BITS-1:0] b,
                                             input logic [EVID_BITS-1:0] e,
                                             input logic pflip,
                                             input logic stop);
    logic p;
    p = (^{b, e}) ^ pflip;
    return {1'b1, b, e, p, stop};
  endfunction

  // Drives the first nbits of a frame, MSB first, one bit per BIT_CLKS
  // cycles. Called and returns on a falling edge; the line keeps the last bit.
  task automatic send_bits(input logic [FL-1:0] frame, input int nbits);
    for (int k = FL - 1; k >= FL - nbits; k--) begin
      cmd_line = frame[k];
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  // Called right after a full frame was sent with nothing pending: the stop
  // sample is in this cycle, valid must appear in the next one.
  task automatic expect_cmd(input string tag, input logic [BUF_BITS-1:0] eb,
                            input logic [EVID_BITS-1:0] ee);
    check_eq({tag, "_valid_early"}, 32'(cmd_valid), 32'd0);
    check_eq({tag, "_busy_stop"}, 32'(busy), 32'd1);
    @(negedge clk);
    check_eq({tag, "_valid"}, 32'(cmd_valid), 32'd1);
    check_eq({tag, "_buffer"}, 32'(cmd_buffer), 32'(eb));
    check_eq({tag, "_evid"}, 32'(cmd_evid), 32'(ee));
    check_eq({tag, "_busy_done"}, 32'(busy), 32'd0);
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    check_eq({tag, "_valid_acked"}, 32'(cmd_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic seen_busy;
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    cmd_line = 1'b0;
    cmd_ack  = 1'b0;
`ifdef SURF_CMD_ERR_COUNT_EN
    err_count_clr = 1'b0;
`endif
    idle(3);
    check_eq("rst_valid", 32'(cmd_valid), 32'd0);
    check_eq("rst_buffer", 32'(cmd_buffer), 32'd0);
    check_eq("rst_evid", 32'(cmd_evid), 32'd0);
    check_eq("rst_err_parity", 32'(err_parity), 32'd0);
    check_eq("rst_err_frame", 32'(err_frame), 32'd0);
    check_eq("rst_overrun", 32'(err_overrun), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(4);

    // Good frame, then ack with nothing pending must be ignored.
    send_bits(mk_frame(2'b10, 12'hA5C, 1'b0, 1'b0), FL);
    expect_cmd("good1", 2'b10, 12'hA5C);
    cmd_ack = 1'b1;
    idle(1);
    cmd_ack = 1'b0;
    idle(1);
    check_eq("stray_ack_valid", 32'(cmd_valid), 32'd0);
    idle(3);

    // Parity bit inverted.
    send_bits(mk_frame(2'b10, 12'hA5C, 1'b1, 1'b0), FL);
    check_eq("par_pulse_early", 32'(err_parity), 32'd0);
    @(negedge clk);
    check_eq("par_pulse", 32'(err_parity), 32'd1);
    check_eq("par_no_frame_err", 32'(err_frame), 32'd0);
    check_eq("par_valid", 32'(cmd_valid), 32'd0);
    check_eq("par_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("par_pulse_end", 32'(err_parity), 32'd0);
    idle(3);

    // One-cycle glitch: rejected at the START sample.
    cmd_line = 1'b1;
    @(negedge clk);
    cmd_line = 1'b0;
    idle(3);
    check_eq("glitch_busy", 32'(busy), 32'd1);
    check_eq("glitch_early", 32'(err_frame), 32'd0);
    @(negedge clk);
    check_eq("glitch_frame_err", 32'(err_frame), 32'd1);
    check_eq("glitch_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("glitch_pulse_end", 32'(err_frame), 32'd0);
    idle(3);
    send_bits(mk_frame(2'b01, 12'h001, 1'b0, 1'b0), FL);
    expect_cmd("after_glitch", 2'b01, 12'h001);
    idle(3);

    // Overrun: second frame dropped while the first is unacked.
    send_bits(mk_frame(2'b11, 12'h100, 1'b0, 1'b0), FL);
    idle(2);
    check_eq("ovr_first_valid", 32'(cmd_valid), 32'd1);
    check_eq("ovr_first_evid", 32'(cmd_evid), 32'h100);
    check_eq("ovr_not_yet", 32'(err_overrun), 32'd0);
    send_bits(mk_frame(2'b10, 12'h0F0, 1'b0, 1'b0), FL);
    idle(2);
    check_eq("ovr_held_valid", 32'(cmd_valid), 32'd1);
    check_eq("ovr_held_buffer", 32'(cmd_buffer), 32'd3);
    check_eq("ovr_held_evid", 32'(cmd_evid), 32'h100);
    check_eq("ovr_set", 32'(err_overrun), 32'd1);
    // Third frame with ack landing on its commit edge.
    send_bits(mk_frame(2'b01, 12'h777, 1'b0, 1'b0), FL);
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    check_eq("swap_valid", 32'(cmd_valid), 32'd1);
    check_eq("swap_buffer", 32'(cmd_buffer), 32'd1);
    check_eq("swap_evid", 32'(cmd_evid), 32'h777);
    @(negedge clk);
    check_eq("swap_valid_hold", 32'(cmd_valid), 32'd1);
    check_eq("ovr_sticky", 32'(err_overrun), 32'd1);
    idle(2);

    // Reset mid-DATA while a command is still pending.
    send_bits(mk_frame(2'b10, 12'hBEE, 1'b0, 1'b0), 6);
    check_eq("mid_busy", 32'(busy), 32'd1);
    rst      = 1'b1;
    cmd_line = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_valid", 32'(cmd_valid), 32'd0);
    check_eq("mid_rst_buffer", 32'(cmd_buffer), 32'd0);
    check_eq("mid_rst_evid", 32'(cmd_evid), 32'd0);
    check_eq("mid_rst_overrun", 32'(err_overrun), 32'd0);
    idle(2);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("post_rst_no_err", 32'({err_parity, err_frame}), 32'd0);
    end
    send_bits(mk_frame(2'b00, 12'hFFF, 1'b0, 1'b0), FL);
    expect_cmd("post_rst", 2'b00, 12'hFFF);
    idle(3);

    // Stop bit forced high, then line stuck high must not re-trigger.
    send_bits(mk_frame(2'b01, 12'h3C3, 1'b0, 1'b1), FL);
    @(negedge clk);
    check_eq("stop1_frame_err", 32'(err_frame), 32'd1);
    check_eq("stop1_no_par_err", 32'(err_parity), 32'd0);
    check_eq("stop1_valid", 32'(cmd_valid), 32'd0);
    seen_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen_busy = seen_busy | busy;
    end
    check_eq("stuck_high_idle", 32'(seen_busy), 32'd0);
    cmd_line = 1'b0;
    idle(4);

`ifdef SURF_CMD_ERR_COUNT_EN
    err_count_clr = 1'b1;
    @(negedge clk);
    err_count_clr = 1'b0;
    check_eq("cnt_cleared", 32'(err_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      send_bits(mk_frame(2'(i), 12'h055 + 12'(i), 1'b1, 1'b0), FL);
      idle(3);
    end
    check_eq("cnt_three", 32'(err_count), 32'd3);
    send_bits(mk_frame(2'b11, 12'h0AA, 1'b1, 1'b0), FL);
    @(negedge clk);
    check_eq("cnt_fourth_pulse", 32'(err_parity), 32'd1);
    check_eq("cnt_before_clr", 32'(err_count), 32'd3);
    err_count_clr = 1'b1;
    @(negedge clk);
    err_count_clr = 1'b0;
    check_eq("cnt_clr_wins", 32'(err_count), 32'd0);
    idle(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
